// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the fetch stage.
//
// Holds the current fetch address and hands pc / pc_plus to IF. Redirects are
// arbitrated exc_req > (eret) > jr > jump > branch_taken. A redirect that
// arrives while stalled is parked in a one-entry pending latch and applied
// when the stall releases. A BOOT/RUN/HALT state machine gates fetching.
//
// Handshake: pc_valid is the "valid" side of the fetch interface and ~stall is
// its "ready" side. A fetch at pc is consumed on a rising edge where
// pc_valid = 1, which already implies stall = 0. The pc only advances on such
// an edge, or on the wake-on-exception edge out of HALT.
//
// Optional feature (macro PC_EPC_EN): adds eret input and epc output. epc
// captures the pc at which an exception was accepted; eret redirects to epc.
//
// Parameters:
//   ADDR_W    width of pc and all target buses
//   RESET_VEC pc loaded on reset
//   EXC_VEC   exception handler address (must be STEP-aligned)
//   STEP      byte increment per sequential fetch (power of two)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hold pc; IF/ID cannot take a fetch
//   halt_req, resume           enter / leave HALT
//   exc_req                    redirect to EXC_VEC (also wakes from HALT)
//   jr, jr_target              register-jump redirect
//   jump, jump_target          direct-jump redirect
//   branch_taken, branch_target taken-branch redirect
//   pc, pc_plus                current fetch address and pc + STEP
//   pc_valid                   pc is a live fetch this cycle
//   misalign                   one-cycle pulse: loaded redirect not aligned
//   halted                     state machine is in HALT
//   eret, epc                  (PC_EPC_EN only) return-from-exception, saved pc
//
// The FSM state is held in the signal "state" (type state_t) for observation.
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_0080,
    parameter int                STEP      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              exc_req,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              pc_valid,
    output logic              misalign,
    output logic              halted
`ifdef PC_EPC_EN
    ,
    input  logic              eret,
    output logic [ADDR_W-1:0] epc
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Redirect ranks for the pending latch; a later redirect during a stall
    // replaces the parked one only if its rank is equal or higher.
`ifdef PC_EPC_EN
    localparam int PRI_W = 3;
    localparam logic [PRI_W-1:0] PRI_EXC  = 3'd4;
    localparam logic [PRI_W-1:0] PRI_ERET = 3'd3;
`else
    localparam int PRI_W = 2;
    localparam logic [PRI_W-1:0] PRI_EXC  = 2'd3;
`endif
    localparam logic [PRI_W-1:0] PRI_JR   = PRI_W'(2);
    localparam logic [PRI_W-1:0] PRI_JUMP = PRI_W'(1);
    localparam logic [PRI_W-1:0] PRI_BR   = PRI_W'(0);

    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              pending_vld, pending_vld_nxt;
    logic [ADDR_W-1:0] pending_tgt, pending_tgt_nxt;
    logic [PRI_W-1:0]  pending_pri, pending_pri_nxt;
    logic              misalign_nxt;

    logic              req_any;
    logic [ADDR_W-1:0] sel_tgt;
    logic [PRI_W-1:0]  sel_pri;
    logic              sel_exc;

`ifdef PC_EPC_EN
    logic [ADDR_W-1:0] epc_nxt;
    logic              load_exc;
`endif

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return (a & STEP_MASK) != '0;
    endfunction

    // Sequential increment wraps modulo 2^ADDR_W; the carry is simply dropped.
    assign pc_plus  = pc + ADDR_W'(STEP);
    assign pc_valid = (state == RUN) && !stall;
    assign halted   = (state == HALT);

    // Redirect arbitration.
    always_comb begin
        req_any = 1'b1;
        sel_tgt = branch_target;
        sel_pri = PRI_BR;
        sel_exc = 1'b0;
        if (exc_req) begin
            sel_tgt = EXC_VEC;
            sel_pri = PRI_EXC;
            sel_exc = 1'b1;
`ifdef PC_EPC_EN
        end else if (eret) begin
            sel_tgt = epc;
            sel_pri = PRI_ERET;
`endif
        end else if (jr) begin
            sel_tgt = jr_target;
            sel_pri = PRI_JR;
        end else if (jump) begin
            sel_tgt = jump_target;
            sel_pri = PRI_JUMP;
        end else if (!branch_taken) begin
            req_any = 1'b0;
        end
    end

    // Next-state / next-pc logic.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pending_vld_nxt = pending_vld;
        pending_tgt_nxt = pending_tgt;
        pending_pri_nxt = pending_pri;
        misalign_nxt    = 1'b0;
`ifdef PC_EPC_EN
        load_exc        = 1'b0;
`endif
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (stall) begin
                    // Park the redirect; exc_req has the top rank so it
                    // always replaces whatever is parked.
                    if (req_any && (!pending_vld || sel_pri >= pending_pri)) begin
                        pending_vld_nxt = 1'b1;
                        pending_tgt_nxt = sel_tgt;
                        pending_pri_nxt = sel_pri;
                    end
                end else begin
                    pending_vld_nxt = 1'b0;
                    if (req_any) begin
                        pc_nxt       = sel_tgt;
                        misalign_nxt = !sel_exc && is_misaligned(sel_tgt);
`ifdef PC_EPC_EN
                        load_exc     = sel_exc;
`endif
                    end else if (pending_vld) begin
                        pc_nxt       = pending_tgt;
                        misalign_nxt = (pending_pri != PRI_EXC) &&
                                       is_misaligned(pending_tgt);
`ifdef PC_EPC_EN
                        load_exc     = (pending_pri == PRI_EXC);
`endif
                    end else begin
                        pc_nxt = pc_plus;
                    end
                    if (halt_req) begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (exc_req) begin
                    pc_nxt    = EXC_VEC;
                    state_nxt = RUN;
`ifdef PC_EPC_EN
                    load_exc  = 1'b1;
`endif
                end else if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

`ifdef PC_EPC_EN
    // epc records the pc current in the cycle the exception is taken.
    assign epc_nxt = load_exc ? pc : epc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            pending_vld <= 1'b0;
            pending_tgt <= '0;
            pending_pri <= '0;
            misalign    <= 1'b0;
`ifdef PC_EPC_EN
            epc         <= RESET_VEC;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pending_vld <= pending_vld_nxt;
            pending_tgt <= pending_tgt_nxt;
            pending_pri <= pending_pri_nxt;
            misalign    <= misalign_nxt;
`ifdef PC_EPC_EN
            epc         <= epc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt_req, resume, exc_req;
  logic        jr, jump, branch_taken;
  logic [31:0] jr_target, jump_target, branch_target;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, misalign, halted;
`ifdef PC_EPC_EN
  logic        eret;
  logic [31:0] epc;
`endif

  int n_vec = 0;
  int n_err = 0;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
    .resume(resume), .exc_req(exc_req),
    .jr(jr), .jr_target(jr_target),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
    .misalign(misalign), .halted(halted)
`ifdef PC_EPC_EN
    , .eret(eret), .epc(epc)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // One row = one clock cycle: inputs driven in that cycle and the outputs
  // expected while those inputs are applied (before the closing edge).
  typedef struct {
    logic        st, hr, rs, ex;
    logic        jr;
    logic [31:0] jr_t;
    logic        jp;
    logic [31:0] jp_t;
    logic        br;
    logic [31:0] br_t;
    logic [31:0] e_pc;
    logic        e_valid, e_mis, e_halt;
  } vec_t;

  vec_t vecs[64];
  int   n_rows = 0;

  task automatic add(input logic st, hr, rs, ex,
                     input logic jrf, input logic [31:0] jrt,
                     input logic jpf, input logic [31:0] jpt,
                     input logic brf, input logic [31:0] brt,
                     input logic [31:0] epc_v, input logic ev, em, eh);
    vecs[n_rows].st = st;  vecs[n_rows].hr = hr;
    vecs[n_rows].rs = rs;  vecs[n_rows].ex = ex;
    vecs[n_rows].jr = jrf; vecs[n_rows].jr_t = jrt;
    vecs[n_rows].jp = jpf; vecs[n_rows].jp_t = jpt;
    vecs[n_rows].br = brf; vecs[n_rows].br_t = brt;
    vecs[n_rows].e_pc = epc_v; vecs[n_rows].e_valid = ev;
    vecs[n_rows].e_mis = em;   vecs[n_rows].e_halt = eh;
    n_rows++;
  endtask

  // driver tasks
  task automatic drive_idle();
    stall = 0; halt_req = 0; resume = 0; exc_req = 0;
    jr = 0; jump = 0; branch_taken = 0;
    jr_target = '0; jump_target = '0; branch_target = '0;
`ifdef PC_EPC_EN
    eret = 0;
`endif
  endtask

  task automatic drive_row(input vec_t v);
    stall = v.st; halt_req = v.hr; resume = v.rs; exc_req = v.ex;
    jr = v.jr; jr_target = v.jr_t;
    jump = v.jp; jump_target = v.jp_t;
    branch_taken = v.br; branch_target = v.br_t;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t v);
    chk($sformatf("row%0d pc", i), pc, v.e_pc);
    chk($sformatf("row%0d pc_plus", i), pc_plus, v.e_pc + 32'd4);
    chk($sformatf("row%0d pc_valid", i), {31'd0, pc_valid}, {31'd0, v.e_valid});
    chk($sformatf("row%0d misalign", i), {31'd0, misalign}, {31'd0, v.e_mis});
    chk($sformatf("row%0d halted", i), {31'd0, halted}, {31'd0, v.e_halt});
  endtask

  initial begin
    rst_n = 0;
    drive_idle();

    //   st hr rs ex  jr jr_t        jp jp_t          br br_t         exp pc        v  m  h
    add(0, 0, 0, 0,  0, 0,          1, 32'h400,      0, 0,           32'h0,        0, 0, 0); // BOOT ignores jump
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h0,        1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h4,        1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h8,        1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          1, 32'h100,      0, 0,           32'hC,        1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          1, 32'h400,      1, 32'h200,     32'h100,      1, 0, 0); // jump > branch
    add(0, 0, 0, 1,  0, 0,          1, 32'h400,      1, 32'h200,     32'h400,      1, 0, 0); // exc > all
    add(0, 0, 0, 0,  1, 32'h40,     1, 32'h900,      1, 32'h200,     32'h80,       1, 0, 0); // jr > jump
    add(1, 0, 0, 0,  0, 0,          0, 0,            1, 32'h300,     32'h40,       0, 0, 0); // stall, park branch
    add(1, 0, 0, 0,  0, 0,          1, 32'h500,      0, 0,           32'h40,       0, 0, 0); // jump overwrites
    add(1, 0, 0, 0,  0, 0,          0, 0,            1, 32'h700,     32'h40,       0, 0, 0); // branch cannot
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h40,       1, 0, 0); // drain
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h500,      1, 0, 0);
    add(1, 0, 0, 0,  0, 0,          1, 32'h600,      0, 0,           32'h504,      0, 0, 0); // park jump
    add(0, 0, 0, 0,  0, 0,          0, 0,            1, 32'h800,     32'h504,      1, 0, 0); // live beats parked
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h800,      1, 0, 0); // pending gone
    add(1, 0, 0, 1,  0, 0,          0, 0,            0, 0,           32'h804,      0, 0, 0); // park exc
    add(1, 0, 0, 0,  1, 32'h1000,   0, 0,            0, 0,           32'h804,      0, 0, 0); // jr cannot replace
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h804,      1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          1, 32'hFFFF_FFFC, 0, 0,          32'h80,       1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'hFFFF_FFFC, 1, 0, 0); // wraps
    add(0, 0, 0, 0,  1, 32'h1002,   0, 0,            0, 0,           32'h0,        1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h1002,     1, 1, 0); // misalign pulse
    add(1, 0, 0, 0,  0, 0,          0, 0,            1, 32'h2001,    32'h1006,     0, 0, 0);
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h1006,     1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          1, 32'h20,       0, 0,           32'h2001,     1, 1, 0); // drained misalign
    add(0, 1, 0, 0,  0, 0,          0, 0,            0, 0,           32'h20,       1, 0, 0); // halt
    add(0, 0, 0, 0,  0, 0,          1, 32'h900,      0, 0,           32'h24,       0, 0, 1); // jump ignored
    add(0, 1, 1, 0,  0, 0,          0, 0,            0, 0,           32'h24,       0, 0, 1); // resume wins
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h24,       1, 0, 0);
    add(1, 1, 0, 0,  0, 0,          0, 0,            0, 0,           32'h28,       0, 0, 0); // halt deferred
    add(0, 1, 0, 0,  0, 0,          0, 0,            0, 0,           32'h28,       1, 0, 0);
    add(0, 0, 0, 1,  0, 0,          0, 0,            0, 0,           32'h2C,       0, 0, 1); // wake on exc
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h80,       1, 0, 0);
    add(0, 0, 0, 0,  0, 0,          0, 0,            0, 0,           32'h84,       1, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    chk("reset pc", pc, 32'h0);
    chk("reset pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("reset misalign", {31'd0, misalign}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
`ifdef PC_EPC_EN
    chk("reset epc", epc, 32'h0);
`endif
    rst_n = 1;

    for (int i = 0; i < n_rows; i++) begin
      drive_row(vecs[i]);
      #1;
      chk_row(i, vecs[i]);
      @(negedge clk);
    end

    // reset mid-operation: misalign high and a misaligned redirect parked
    drive_idle();
    jr = 1; jr_target = 32'h3002;
    @(posedge clk); #2;
    chk("mid pc", pc, 32'h3002);
    chk("mid misalign", {31'd0, misalign}, 32'd1);
    stall = 1; jr_target = 32'h3006;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("async reset pc", pc, 32'h0);
    chk("async reset misalign", {31'd0, misalign}, 32'd0);
    chk("async reset pc_valid", {31'd0, pc_valid}, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reboot pc", pc, 32'h0);
    chk("reboot pc_valid", {31'd0, pc_valid}, 32'd0);
    @(negedge clk); #1;
    chk("reboot run pc", pc, 32'h0);
    chk("reboot run pc_valid", {31'd0, pc_valid}, 32'd1);
    chk("reboot misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk); #1;
    chk("no stale pending pc", pc, 32'h4);
    chk("no stale misalign", {31'd0, misalign}, 32'd0);

`ifdef PC_EPC_EN
    // exception saves pc, eret returns to it
    jump = 1; jump_target = 32'h60;
    @(negedge clk); drive_idle(); #1;
    chk("epc pre pc", pc, 32'h60);
    exc_req = 1;
    @(negedge clk); drive_idle(); #1;
    chk("epc exc pc", pc, 32'h80);
    chk("epc saved", epc, 32'h60);
    eret = 1;
    @(negedge clk); drive_idle(); #1;
    chk("eret pc", pc, 32'h60);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage.
- Holds the current fetch address and supplies pc / pc_plus for IF.
- Arbitrates prioritised redirects: exception, register jump, jump, branch.
- Supports stall with a pending-redirect latch, a halt/resume state machine and an alignment check.

Parameters:
- ADDR_W, 32: width of pc and all target buses.
- RESET_VEC, 0: pc value loaded on reset.
- EXC_VEC, 32'h0000_0080: exception handler address.
- STEP, 4: byte increment per sequential fetch; must be a power of two.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold pc; IF/ID cannot accept a new fetch.
- halt_req  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- exc_req  in  1  exception redirect to EXC_VEC.
- jr  in  1  register-jump redirect.
- jr_target  in  ADDR_W  register-jump address.
- jump  in  1  direct-jump redirect.
- jump_target  in  ADDR_W  direct-jump address, already a byte address.
- branch_taken  in  1  taken-branch redirect.
- branch_target  in  ADDR_W  branch address.
- pc  out  ADDR_W  current fetch address.
- pc_plus  out  ADDR_W  pc + STEP, combinational from pc.
- pc_valid  out  1  pc is a live fetch this cycle.
- misalign  out  1  one-cycle pulse when an accepted redirect target is not STEP-aligned.
- halted  out  1  state == HALT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_VEC, state = BOOT, pending_vld = 0.
  - pc_valid = 0, misalign = 0, halted = 0.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts one cycle after rst_n deasserts; pc_valid = 0.
  - Next state RUN; pc stays RESET_VEC.
  - Redirect inputs are ignored in BOOT.
- RUN: pc_valid = 1 unless stall.
- Redirect priority: exc_req > jr > jump > branch_taken.
- Selected target sel_tgt: EXC_VEC, jr_target, jump_target or branch_target.
- Next pc in RUN, stall = 0:
  - If any redirect is asserted this cycle: pc <= sel_tgt.
  - Else if pending_vld: pc <= pending_tgt, and pending_vld clears.
  - Else: pc <= pc + STEP.
  - A same-cycle redirect beats the pending value, and pending_vld still clears.
- Next pc in RUN, stall = 1:
  - pc holds.
  - Any redirect is latched: pending_tgt <= sel_tgt, pending_vld <= 1.
  - A later redirect during the same stall overwrites pending_tgt only if it has equal or higher priority than the stored one. A 2-bit pending_pri is kept for this.
  - exc_req always overwrites.
- Arithmetic: pc + STEP wraps modulo 2^ADDR_W with no carry out. Example: pc = 32'hFFFF_FFFC with STEP = 4 gives 0.
- Alignment:
  - misalign = 1 for one cycle when a redirect (immediate or drained from pending) loads a target with target % STEP != 0.
  - The pc is still loaded with the raw target. Trap handling is downstream.
  - EXC_VEC must be aligned; misalign is never raised for it.
- HALT:
  - Entered from RUN when halt_req = 1 and stall = 0.
  - pc holds the next sequential or redirect value computed that cycle. The instruction at the old pc is the last fetched.
  - In HALT: pc_valid = 0, halted = 1.
  - jr, jump and branch inputs are ignored.
  - exc_req in HALT: pc <= EXC_VEC and state <= RUN next cycle. This is the wake-on-exception path.
  - resume = 1 (with no exc_req): state <= RUN, pc unchanged.
  - halt_req and resume both high in HALT: resume wins.
- Simultaneous halt_req with stall = 1: the halt is deferred until stall = 0.
- Reset mid-operation: the pending redirect is discarded and there is no residual pulse on misalign.

Optional Feature:
- Macro PC_EPC_EN.
- Enabled, adds these ports:
  - eret in 1: return from exception.
  - epc out ADDR_W: saved exception pc.
- On an accepted exc_req (immediate or drained), epc <= the pc of the cycle the exception was accepted.
- eret in RUN with stall = 0 and no exc_req: pc <= epc.
  - Priority is below exc_req and above jr.
  - eret is latched into pending like any other redirect when stalled.
- epc resets to RESET_VEC.
- Disabled: no eret or epc ports and no epc register; exception behaviour is otherwise identical.

Test Plan:
- Reset/boot: rst_n low, then high.
  - pc = 0 and pc_valid = 0 for one cycle.
  - Then pc = 0, 4, 8, 12 on successive cycles with pc_valid = 1.
- Priority: at pc = 32'h100, assert jump (32'h400) and branch_taken (32'h200) together -> next pc = 32'h400.
  - Add exc_req in the same cycle -> next pc = 32'h80.
- Stall with pending:
  - pc = 32'h40, stall = 1 for 3 cycles; branch_taken to 32'h300 in cycle 1; jump to 32'h500 in cycle 2.
  - pc holds 32'h40 throughout; on release, pc = 32'h500 then 32'h504.
- Wrap/misalign:
  - pc = 32'hFFFF_FFFC, no redirect -> next pc = 0.
  - jr_target = 32'h1002 -> pc = 32'h1002 with misalign high for exactly one cycle.
- Halt:
  - halt_req at pc = 32'h20 -> halted = 1, pc = 32'h24 and held, pc_valid = 0.
  - jump is ignored while halted.
  - resume -> pc = 32'h24 then 32'h28.
  - In a separate run, exc_req while halted -> pc = 32'h80 and RUN.
- PC_EPC_EN: exc_req accepted at pc = 32'h60 -> epc = 32'h60 and pc = 32'h80; later eret -> pc = 32'h60.
